seg_chase_animator: RTL and testbench
=====================================

// Module: seg_chase_animator
// PURPOSE
//  Parametrised seven-segment chase animation for the 8-digit board display.
//  - Walks a lit pattern around DIGITS digits at a prescaled rate.
//  - Selectable direction.
//  - Two modes: square-chase (upper/lower square per digit) and perimeter-trace (single segment).
//  - Drives an/sseg directly (active-low), sits between top-level switches and the display pins.
// PARAMETERS
//  DIGITS    4   digits used, 2..8; an[i] for i>=DIGITS is held 1
//  TICK_DIV  2**26  clk cycles per animation step, >=2
//  POS_W     $clog2(2*DIGITS+4)  position register width (derived, do not override)
// PORTS
//  clk   in   1      system clock
//  rst   in   1      asynchronous reset, active-high
//  en    in   1      1 = animate and display; 0 = blank outputs, freeze state
//  dir   in   1      0 = position +1 per step, 1 = position -1 per step
//  mode  in   1      0 = square-chase, 1 = perimeter-trace
//  an    out  8      digit enables, active-low, an[0] = rightmost digit
//  sseg  out  8      segments, active-low, {dp,g,f,e,d,c,b,a}
//  pos   out  POS_W  current animation position (debug)
//  wrap  out  1      1-cycle pulse when position wraps in either direction
// BEHAVIOUR
//  Reset (async, rst=1):
//   - outputs: an=8'hFF, sseg=8'hFF, pos=0, wrap=0
//   - internals: prescaler=0, mode_q=0
//  Prescaler:
//   - counts 0..TICK_DIV-1 while en=1
//   - tick = (count==TICK_DIV-1); count returns to 0 on tick
//   - en=0: prescaler and pos hold their values
//  Step length:
//   - L = 2*DIGITS in mode 0; L = 2*DIGITS+4 in mode 1
//   - on tick: pos <= (pos+1)%L (dir=0) or (pos==0 ? L-1 : pos-1) (dir=1)
//   - wrap=1 in the cycle after a tick that moved L-1->0 (dir=0) or 0->L-1 (dir=1)
//  Mode change:
//   - mode_q registers mode; when mode != mode_q, the next edge sets pos=0, prescaler=0, wrap=0
//   - this clearing applies even when en=0
//   - mode change in the same cycle as tick: the clear wins
//  Direction change: takes effect at the next tick; no reset of pos.
//  Decode (registered; an/sseg follow pos with 1 clk latency):
//   mode 0, k=pos:
//    - k<DIGITS: sseg=8'b10011100 (upper square a,b,f,g), digit k
//    - else: sseg=8'b10100011 (lower square c,d,e,g), digit 2*DIGITS-1-k
//   mode 1, D=DIGITS, single segment:
//    - k<D: seg a on digit D-1-k
//    - k=D: b on digit 0; k=D+1: c on digit 0
//    - D+2<=k<2D+2: d on digit k-D-2
//    - k=2D+2: e on digit D-1; k=2D+3: f on digit D-1
//  Register updates: next cycle after en=0, an=8'hFF, sseg=8'hFF; exactly one an bit is low when en=1.
//  Illegal pos (pos>=L, e.g. after a mode change in flight) is never decoded; it is cleared by the mode-change rule.
// TESTING (DIGITS=4, TICK_DIV=4 for all sims)
//  1. Reset mid-run: assert rst asynchronously between edges
//     -> an=FF, sseg=FF, pos=0 immediately; first tick 4 clks after release with en=1.
//  2. mode=0, dir=0, en=1, 32 clks
//     -> pos 0..7, an FE,FD,FB,F7,F7,FB,FD,FE; sseg 9C x4 then A3 x4; wrap pulses once at 7->0.
//  3. mode=0, dir=1 from pos=0
//     -> pos 7,6,5; first step shows sseg=A3, an=FE; wrap pulses on 0->7.
//  4. mode=1, dir=0, 48 clks
//     -> 12 positions; sseg=FE(a) an F7,FB,FD,FE; FD(b),FB(c) on FE; F7(d) FE..F7; EF(e),DF(f) on F7.
//  5. en dropped at pos=3 for 10 clks
//     -> an/sseg=FF next cycle; pos stays 3; resumes with prescaler count preserved.
//  6. Toggle mode at pos=5 coincident with tick
//     -> pos=0, wrap=0, prescaler=0 next cycle; new-mode decode follows one cycle later.

Source files
------------

// File: rtl/seg_chase_animator.sv
// Seven-segment chase animation: walks a lit square or a single perimeter segment
// around DIGITS digits at a prescaled rate and drives active-low an/sseg directly.
module seg_chase_animator #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 2**26,
    parameter int POS_W    = $clog2(2*DIGITS+4)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    output logic [7:0]       an,
    output logic [7:0]       sseg,
    output logic [POS_W-1:0] pos,
    output logic             wrap
);

    localparam int               CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV-1);
    localparam logic [POS_W-1:0] LEN0    = POS_W'(2*DIGITS);
    localparam logic [POS_W-1:0] LEN1    = POS_W'(2*DIGITS+4);

    localparam logic [7:0] SEG_UP = 8'b1001_1100;
    localparam logic [7:0] SEG_LO = 8'b1010_0011;
    localparam logic [7:0] SEG_A  = 8'b1111_1110;
    localparam logic [7:0] SEG_B  = 8'b1111_1101;
    localparam logic [7:0] SEG_C  = 8'b1111_1011;
    localparam logic [7:0] SEG_D  = 8'b1111_0111;
    localparam logic [7:0] SEG_E  = 8'b1110_1111;
    localparam logic [7:0] SEG_F  = 8'b1101_1111;

    logic [CNT_W-1:0] cnt_r;
    logic             mode_q_r;
    logic [POS_W-1:0] pos_r;
    logic             wrap_r;
    logic [7:0]       an_r;
    logic [7:0]       sseg_r;

    logic             tick_s;
    logic             mode_chg_s;
    logic             at_end_s;
    logic             at_start_s;
    logic [POS_W-1:0] len_s;
    logic [POS_W-1:0] pos_nxt_s;
    logic             wrap_nxt_s;
    logic [15:0]      dec_s;

    // Maps a position to {an, sseg}; positions outside the current length blank the display.
    function automatic logic [15:0] decode_f(input logic [POS_W-1:0] k,
                                             input logic             m,
                                             input logic [POS_W-1:0] len);
        int         kk;
        int         dig;
        logic [7:0] seg;
        logic [7:0] anv;
        kk  = int'(k);
        dig = 0;
        seg = 8'hFF;
        if (k >= len) begin
            seg = 8'hFF;
        end else if (!m) begin
            if (kk < DIGITS) begin
                seg = SEG_UP;
                dig = kk;
            end else begin
                seg = SEG_LO;
                dig = 2*DIGITS - 1 - kk;
            end
        end else begin
            if (kk < DIGITS) begin
                seg = SEG_A;
                dig = DIGITS - 1 - kk;
            end else if (kk == DIGITS) begin
                seg = SEG_B;
                dig = 0;
            end else if (kk == DIGITS + 1) begin
                seg = SEG_C;
                dig = 0;
            end else if (kk < 2*DIGITS + 2) begin
                seg = SEG_D;
                dig = kk - DIGITS - 2;
            end else if (kk == 2*DIGITS + 2) begin
                seg = SEG_E;
                dig = DIGITS - 1;
            end else begin
                seg = SEG_F;
                dig = DIGITS - 1;
            end
        end
        if (k < len) begin
            anv = ~(8'h01 << dig);
        end else begin
            anv = 8'hFF;
        end
        return {anv, seg};
    endfunction

    // Step arithmetic, wrap detection and decode of the current position.
    always_comb begin
        tick_s     = en && (cnt_r == CNT_MAX);
        mode_chg_s = (mode != mode_q_r);
        if (mode_q_r) begin
            len_s = LEN1;
        end else begin
            len_s = LEN0;
        end
        at_end_s   = (pos_r == len_s - POS_W'(1));
        at_start_s = (pos_r == '0);
        if (dir) begin
            pos_nxt_s  = at_start_s ? len_s - POS_W'(1) : pos_r - POS_W'(1);
            wrap_nxt_s = at_start_s;
        end else begin
            pos_nxt_s  = at_end_s ? '0 : pos_r + POS_W'(1);
            wrap_nxt_s = at_end_s;
        end
        dec_s = decode_f(pos_r, mode_q_r, len_s);
    end

    // Prescaler, position and wrap; a mode change clears everything and outranks a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= '0;
            pos_r    <= '0;
            wrap_r   <= 1'b0;
            mode_q_r <= 1'b0;
        end else begin
            mode_q_r <= mode;
            if (mode_chg_s) begin
                cnt_r  <= '0;
                pos_r  <= '0;
                wrap_r <= 1'b0;
            end else if (en) begin
                if (tick_s) begin
                    cnt_r  <= '0;
                    pos_r  <= pos_nxt_s;
                    wrap_r <= wrap_nxt_s;
                end else begin
                    cnt_r  <= cnt_r + CNT_W'(1);
                    wrap_r <= 1'b0;
                end
            end else begin
                wrap_r <= 1'b0;
            end
        end
    end

    // Registered display drive; blank whenever animation is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_r   <= 8'hFF;
            sseg_r <= 8'hFF;
        end else if (en) begin
            an_r   <= dec_s[15:8];
            sseg_r <= dec_s[7:0];
        end else begin
            an_r   <= 8'hFF;
            sseg_r <= 8'hFF;
        end
    end

    assign an   = an_r;
    assign sseg = sseg_r;
    assign pos  = pos_r;
    assign wrap = wrap_r;

endmodule

// File: tb/tb_seg_chase_animator.sv
// Table-driven bench for seg_chase_animator (DIGITS=4, TICK_DIV=4) with
// hand-written reset sequences.
module tb_seg_chase_animator;

    logic       clk;
    logic       rst;
    logic       en;
    logic       dir;
    logic       mode;
    logic [7:0] an;
    logic [7:0] sseg;
    logic [3:0] pos;
    logic       wrap;

    int errors;
    int checks;

    typedef struct {
        int         ncyc;
        logic       en;
        logic       dir;
        logic       mode;
        logic [3:0] pos;
        logic [7:0] an;
        logic [7:0] sseg;
        logic       wrap;
    } vec_t;

    vec_t vq[$];

    seg_chase_animator #(.DIGITS(4), .TICK_DIV(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .dir  (dir),
        .mode (mode),
        .an   (an),
        .sseg (sseg),
        .pos  (pos),
        .wrap (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input int n, input logic e, input logic d, input logic m,
                       input logic [3:0] p, input logic [7:0] a, input logic [7:0] s,
                       input logic w);
        vec_t v;
        v.ncyc = n; v.en = e; v.dir = d; v.mode = m;
        v.pos = p; v.an = a; v.sseg = s; v.wrap = w;
        vq.push_back(v);
    endtask

    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
        end
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;

        // ncyc, en, dir, mode, pos, an, sseg, wrap
        // square-chase forward, wrap at 7->0
        add(1, 1'b1, 1'b0, 1'b0, 4'd0, 8'hFE, 8'h9C, 1'b0);
        add(4, 1'b1, 1'b0, 1'b0, 4'd1, 8'hFD, 8'h9C, 1'b0);
        add(4, 1'b1, 1'b0, 1'b0, 4'd2, 8'hFB, 8'h9C, 1'b0);
        add(4, 1'b1, 1'b0, 1'b0, 4'd3, 8'hF7, 8'h9C, 1'b0);
        add(4, 1'b1, 1'b0, 1'b0, 4'd4, 8'hF7, 8'hA3, 1'b0);
        add(4, 1'b1, 1'b0, 1'b0, 4'd5, 8'hFB, 8'hA3, 1'b0);
        add(4, 1'b1, 1'b0, 1'b0, 4'd6, 8'hFD, 8'hA3, 1'b0);
        add(4, 1'b1, 1'b0, 1'b0, 4'd7, 8'hFE, 8'hA3, 1'b0);
        add(3, 1'b1, 1'b0, 1'b0, 4'd0, 8'hFE, 8'hA3, 1'b1);
        add(1, 1'b1, 1'b0, 1'b0, 4'd0, 8'hFE, 8'h9C, 1'b0);
        // square-chase backward from 0, wrap on 0->7
        add(3, 1'b1, 1'b1, 1'b0, 4'd7, 8'hFE, 8'h9C, 1'b1);
        add(1, 1'b1, 1'b1, 1'b0, 4'd7, 8'hFE, 8'hA3, 1'b0);
        add(4, 1'b1, 1'b1, 1'b0, 4'd6, 8'hFD, 8'hA3, 1'b0);
        add(4, 1'b1, 1'b1, 1'b0, 4'd5, 8'hFB, 8'hA3, 1'b0);
        add(2, 1'b1, 1'b1, 1'b0, 4'd5, 8'hFB, 8'hA3, 1'b0);
        // mode toggle coincident with tick at pos 5
        add(1, 1'b1, 1'b1, 1'b1, 4'd0, 8'hFB, 8'hA3, 1'b0);
        add(1, 1'b1, 1'b1, 1'b1, 4'd0, 8'hF7, 8'hFE, 1'b0);
        // perimeter-trace forward, 12 positions
        add(4, 1'b1, 1'b0, 1'b1, 4'd1,  8'hFB, 8'hFE, 1'b0);
        add(4, 1'b1, 1'b0, 1'b1, 4'd2,  8'hFD, 8'hFE, 1'b0);
        add(4, 1'b1, 1'b0, 1'b1, 4'd3,  8'hFE, 8'hFE, 1'b0);
        add(4, 1'b1, 1'b0, 1'b1, 4'd4,  8'hFE, 8'hFD, 1'b0);
        add(4, 1'b1, 1'b0, 1'b1, 4'd5,  8'hFE, 8'hFB, 1'b0);
        add(4, 1'b1, 1'b0, 1'b1, 4'd6,  8'hFE, 8'hF7, 1'b0);
        add(4, 1'b1, 1'b0, 1'b1, 4'd7,  8'hFD, 8'hF7, 1'b0);
        add(4, 1'b1, 1'b0, 1'b1, 4'd8,  8'hFB, 8'hF7, 1'b0);
        add(4, 1'b1, 1'b0, 1'b1, 4'd9,  8'hF7, 8'hF7, 1'b0);
        add(4, 1'b1, 1'b0, 1'b1, 4'd10, 8'hF7, 8'hEF, 1'b0);
        add(4, 1'b1, 1'b0, 1'b1, 4'd11, 8'hF7, 8'hDF, 1'b0);
        add(3, 1'b1, 1'b0, 1'b1, 4'd0,  8'hF7, 8'hDF, 1'b1);
        add(1, 1'b1, 1'b0, 1'b1, 4'd0,  8'hF7, 8'hFE, 1'b0);
        add(12, 1'b1, 1'b0, 1'b1, 4'd3, 8'hFE, 8'hFE, 1'b0);
        // en dropped at pos 3 for 10 clocks, prescaler count preserved
        add(1, 1'b0, 1'b0, 1'b1, 4'd3, 8'hFF, 8'hFF, 1'b0);
        add(9, 1'b0, 1'b0, 1'b1, 4'd3, 8'hFF, 8'hFF, 1'b0);
        add(2, 1'b1, 1'b0, 1'b1, 4'd3, 8'hFE, 8'hFE, 1'b0);
        add(1, 1'b1, 1'b0, 1'b1, 4'd4, 8'hFE, 8'hFE, 1'b0);
        add(1, 1'b1, 1'b0, 1'b1, 4'd4, 8'hFE, 8'hFD, 1'b0);
        // mode change while disabled mid-count clears pos and prescaler
        add(1, 1'b0, 1'b0, 1'b0, 4'd0, 8'hFF, 8'hFF, 1'b0);
        add(3, 1'b1, 1'b0, 1'b0, 4'd0, 8'hFE, 8'h9C, 1'b0);
        add(1, 1'b1, 1'b0, 1'b0, 4'd1, 8'hFE, 8'h9C, 1'b0);

        rst  = 1'b1;
        en   = 1'b1;
        dir  = 1'b0;
        mode = 1'b0;
        step(2);
        chk("reset an",   an,         8'hFF);
        chk("reset sseg", sseg,       8'hFF);
        chk("reset pos",  {4'd0, pos}, 8'h00);
        chk("reset wrap", {7'd0, wrap}, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            en   = vq[i].en;
            dir  = vq[i].dir;
            mode = vq[i].mode;
            step(vq[i].ncyc);
            chk($sformatf("vec%0d pos", i),  {4'd0, pos},  {4'd0, vq[i].pos});
            chk($sformatf("vec%0d an", i),   an,           vq[i].an);
            chk($sformatf("vec%0d sseg", i), sseg,         vq[i].sseg);
            chk($sformatf("vec%0d wrap", i), {7'd0, wrap}, {7'd0, vq[i].wrap});
        end

        // asynchronous reset between edges while running
        #3;
        rst = 1'b1;
        #1;
        chk("async rst an",   an,           8'hFF);
        chk("async rst sseg", sseg,         8'hFF);
        chk("async rst pos",  {4'd0, pos},  8'h00);
        chk("async rst wrap", {7'd0, wrap}, 8'h00);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        en   = 1'b1;
        dir  = 1'b0;
        mode = 1'b0;
        step(3);
        chk("post-rst pos before tick", {4'd0, pos}, 8'h00);
        step(1);
        chk("post-rst pos first tick",  {4'd0, pos}, 8'h01);
        chk("post-rst an",   an,   8'hFE);
        chk("post-rst sseg", sseg, 8'h9C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
